axi_wr_burst_engine: RTL and testbench
======================================

# axi_wr_burst_engine

Parametrised slave-side AXI4 write-path model: accepts write addresses into an outstanding-command queue of depth DEPTH. It consumes W beats against the head command, computing each beat address for FIXED, INCR and WRAP bursts, and drives a registered memory write port. It checks WLAST against the burst length and returns B responses with ID in order through a response queue. It is the multi-outstanding, ID-aware, width-generic successor of the single-transaction write-channel FSM in the AXI verification suite.

## Interface
- AW, default 32, address width
- DW, default 64, data width; power of 2, 8..1024; strobe width DW/8
- IDW, default 4, ID width
- DEPTH, default 4, command-queue and B-queue depth; power of 2, >= 2
- axi_aclk  in  1  clock
- rst  in  1  synchronous, active-high reset
- s_awid / s_awaddr / s_awlen / s_awsize / s_awburst  in  IDW / AW / 8 / 3 / 2  write address payload
- s_awvalid  in  1;  s_awready  out  1  write address handshake
- s_wdata / s_wstrb / s_wlast  in  DW / DW/8 / 1  write data payload
- s_wvalid  in  1;  s_wready  out  1  write data handshake
- s_bid / s_bresp  out  IDW / 2  write response payload
- s_bvalid  out  1;  s_bready  in  1  write response handshake
- mem_we  out  1  registered beat write strobe
- mem_addr / mem_wdata / mem_wstrb  out  AW / DW / DW/8  registered beat payload
- cmd_count / b_count  out  clog2(DEPTH)+1 each  queue occupancies

## Operation
- Command queue: circular FIFO of {id, addr, len, size, burst}.
  - s_awready = (cmd_count < DEPTH), combinational from the count.
  - Push on s_awvalid && s_awready.
  - Pop when the head burst's final beat is accepted.
  - Push and pop in the same cycle leave the count unchanged.
- W engine FSM, states IDLE and BURST:
  - IDLE: if cmd_count != 0, load the head entry into beat_addr, beats_left = len, err = 0; go to BURST. s_wready = 0 in IDLE.
  - BURST: s_wready = (b_count < DEPTH). Each accepted beat (s_wvalid && s_wready) is one beat.
  - is_last = (beats_left == 0). If s_wlast != is_last, set err (sticky for the burst).
  - Accepted beat that is not last: beats_left decrements; beat_addr advances.
  - Accepted last beat: pop the command queue, push {id, err ? 2'b10 : 2'b00} into the B queue, go to IDLE.
  - Early WLAST does not end the burst; the engine still consumes len+1 beats.
- Burst type errors (all set err):
  - size > log2(DW/8).
  - burst == 2'b11 (reserved); the burst is treated as INCR.
  - WRAP with len not in {1,3,7,15}; the burst is treated as INCR.
- Beat address advance, all arithmetic modulo 2^AW, bytes = 1 << size:
  - FIXED: unchanged.
  - INCR: addr + bytes; 4 KB crossing is not checked.
  - WRAP: wb = (len+1) << size; next = (addr & ~(wb-1)) | ((addr + bytes) & (wb-1)).
- Memory port: on every accepted beat, the next cycle shows mem_we = 1, mem_addr = current beat_addr, mem_wdata/mem_wstrb = captured s_wdata/s_wstrb. Strobes pass through unmodified.
- B queue: circular FIFO of {id, resp}.
  - s_bvalid = (b_count != 0); s_bid and s_bresp come from the head.
  - Pop on s_bvalid && s_bready.
  - Push and pop in the same cycle leave the count unchanged.
- Responses are returned in AW acceptance order; IDs are not reordered.

## Timing
- Reset values:
  - Queues empty; cmd_count = b_count = 0.
  - s_awready = 1, s_wready = 0, s_bvalid = 0, s_bid = 0, s_bresp = 0.
  - FSM in IDLE.
  - mem_we = 0, mem_addr = 0, mem_wdata = 0, mem_wstrb = 0.
- Reset mid-burst: the in-flight burst is dropped, no B response is issued, and queued commands and responses are discarded.
- AW to first s_wready: 2 cycles (push at edge N, IDLE load at edge N+1, s_wready high during cycle N+1).
- Throughput:
  - One beat per cycle within a burst.
  - One idle cycle (IDLE load) between consecutive bursts.
  - Last W beat to s_bvalid: 1 cycle.
  - Beat to mem_we: 1 cycle.
- W beats may arrive before their AW; s_wready stays 0 until a command is loaded.
- When the B queue is full, s_wready drops. This back-pressures W only; AW acceptance continues while the command queue has space.
- No combinational path from s_wvalid to s_wready, from s_bready to s_bvalid, or from s_awvalid to s_awready.

## Test plan
- INCR, AW id=3, addr 0x100, len 3, size 3, four beats, WLAST on beat 4:
  - mem_addr 0x100, 0x108, 0x110, 0x118 on four consecutive cycles.
  - Then s_bid = 3, s_bresp = 00.
- WRAP, addr 0x118, len 3, size 3: mem_addr 0x118, 0x100, 0x108, 0x110; bresp 00.
- FIXED, addr 0x40, len 2: mem_addr 0x40 on all three beats.
- Error cases:
  - INCR len 3 with WLAST on beat 2: four beats still consumed, bresp 10.
  - WRAP with len 2: INCR addresses, bresp 10.
- DEPTH=4 back-pressure:
  - Five AWs with s_wvalid = 0: s_awready falls after the 4th; the 5th is accepted one cycle after the first burst completes.
  - s_bready = 0 with DEPTH single-beat bursts: s_wready drops after 4 responses queue; draining one B restores it.
- Assert rst during beat 2 of a len-3 burst:
  - All outputs reach their reset values the next cycle; no B response is issued.
  - A new AW after reset completes normally.

Source files
------------

// File: rtl/axi_wr_burst_engine.sv
// AXI4 slave write path: AW command queue, W beat engine with FIXED/INCR/WRAP
// address generation, registered memory write port and in-order B response queue.
module axi_wr_burst_engine #(
    parameter int AW    = 32,
    parameter int DW    = 64,
    parameter int IDW   = 4,
    parameter int DEPTH = 4
) (
    input  logic                      axi_aclk,
    input  logic                      rst,
    input  logic [IDW-1:0]            s_awid,
    input  logic [AW-1:0]             s_awaddr,
    input  logic [7:0]                s_awlen,
    input  logic [2:0]                s_awsize,
    input  logic [1:0]                s_awburst,
    input  logic                      s_awvalid,
    output logic                      s_awready,
    input  logic [DW-1:0]             s_wdata,
    input  logic [DW/8-1:0]           s_wstrb,
    input  logic                      s_wlast,
    input  logic                      s_wvalid,
    output logic                      s_wready,
    output logic [IDW-1:0]            s_bid,
    output logic [1:0]                s_bresp,
    output logic                      s_bvalid,
    input  logic                      s_bready,
    output logic                      mem_we,
    output logic [AW-1:0]             mem_addr,
    output logic [DW-1:0]             mem_wdata,
    output logic [DW/8-1:0]           mem_wstrb,
    output logic [$clog2(DEPTH):0]    cmd_count,
    output logic [$clog2(DEPTH):0]    b_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [2:0] MAXSZ = 3'($clog2(DW/8));

    typedef enum logic {IDLE, BURST} state_t;

    logic [IDW-1:0] cq_id_q    [DEPTH];
    logic [AW-1:0]  cq_addr_q  [DEPTH];
    logic [7:0]     cq_len_q   [DEPTH];
    logic [2:0]     cq_size_q  [DEPTH];
    logic [1:0]     cq_burst_q [DEPTH];
    logic [PW-1:0]  cq_wr_q, cq_rd_q;
    logic [CW-1:0]  cq_cnt_q;

    logic [IDW-1:0] bq_id_q   [DEPTH];
    logic [1:0]     bq_resp_q [DEPTH];
    logic [PW-1:0]  bq_wr_q, bq_rd_q;
    logic [CW-1:0]  bq_cnt_q;

    state_t         state_q, state_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [7:0]     left_q, left_d;
    logic [7:0]     len_q, len_d;
    logic [2:0]     size_q, size_d;
    logic [1:0]     burst_q, burst_d;
    logic           err_q, err_d;

    logic           mem_we_q;
    logic [AW-1:0]  mem_addr_q;
    logic [DW-1:0]  mem_wdata_q;
    logic [DW/8-1:0] mem_wstrb_q;

    logic           aw_push, w_beat, is_last, w_done, b_pop, wrap_ok, bad_type;
    logic [1:0]     b_resp_new;
    logic [AW-1:0]  bytes, wmask, next_addr;
    logic [7:0]     hd_len;
    logic [1:0]     hd_burst;

    assign s_awready = (cq_cnt_q != CW'(DEPTH));
    assign s_wready  = (state_q == BURST) && (bq_cnt_q != CW'(DEPTH));
    assign s_bvalid  = (bq_cnt_q != '0);
    assign s_bid     = s_bvalid ? bq_id_q[bq_rd_q]   : '0;
    assign s_bresp   = s_bvalid ? bq_resp_q[bq_rd_q] : '0;
    assign cmd_count = cq_cnt_q;
    assign b_count   = bq_cnt_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;

    assign aw_push    = s_awvalid && s_awready;
    assign w_beat     = s_wvalid && s_wready;
    assign is_last    = (left_q == 8'd0);
    assign w_done     = w_beat && is_last;
    assign b_pop      = s_bvalid && s_bready;
    assign b_resp_new = (err_q || (s_wlast != is_last)) ? 2'b10 : 2'b00;

    assign hd_len   = cq_len_q[cq_rd_q];
    assign hd_burst = cq_burst_q[cq_rd_q];
    assign wrap_ok  = (hd_len == 8'd1) || (hd_len == 8'd3) || (hd_len == 8'd7) || (hd_len == 8'd15);
    // Reserved bursts and illegal WRAP lengths fall back to INCR addressing.
    assign bad_type = (hd_burst == 2'b11) || ((hd_burst == 2'b10) && !wrap_ok);

    assign bytes = AW'(1) << size_q;
    assign wmask = ((AW'(len_q) + AW'(1)) << size_q) - AW'(1);

    always_comb begin
        next_addr = addr_q + bytes;
        case (burst_q)
            2'b00:   next_addr = addr_q;
            2'b10:   next_addr = (addr_q & ~wmask) | ((addr_q + bytes) & wmask);
            default: next_addr = addr_q + bytes;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        left_d  = left_q;
        len_d   = len_q;
        size_d  = size_q;
        burst_d = burst_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (cq_cnt_q != '0) begin
                    addr_d  = cq_addr_q[cq_rd_q];
                    left_d  = hd_len;
                    len_d   = hd_len;
                    size_d  = cq_size_q[cq_rd_q];
                    burst_d = bad_type ? 2'b01 : hd_burst;
                    err_d   = bad_type || (cq_size_q[cq_rd_q] > MAXSZ);
                    state_d = BURST;
                end
            end
            BURST: begin
                if (w_beat) begin
                    err_d = err_q || (s_wlast != is_last);
                    if (is_last) begin
                        state_d = IDLE;
                    end else begin
                        left_d = left_q - 8'd1;
                        addr_d = next_addr;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge axi_aclk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            left_q      <= '0;
            len_q       <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            err_q       <= 1'b0;
            cq_wr_q     <= '0;
            cq_rd_q     <= '0;
            cq_cnt_q    <= '0;
            bq_wr_q     <= '0;
            bq_rd_q     <= '0;
            bq_cnt_q    <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            left_q   <= left_d;
            len_q    <= len_d;
            size_q   <= size_d;
            burst_q  <= burst_d;
            err_q    <= err_d;
            if (aw_push) cq_wr_q <= cq_wr_q + PW'(1);
            if (w_done)  cq_rd_q <= cq_rd_q + PW'(1);
            if (aw_push && !w_done)      cq_cnt_q <= cq_cnt_q + CW'(1);
            else if (!aw_push && w_done) cq_cnt_q <= cq_cnt_q - CW'(1);
            if (w_done) bq_wr_q <= bq_wr_q + PW'(1);
            if (b_pop)  bq_rd_q <= bq_rd_q + PW'(1);
            if (w_done && !b_pop)      bq_cnt_q <= bq_cnt_q + CW'(1);
            else if (!w_done && b_pop) bq_cnt_q <= bq_cnt_q - CW'(1);
            mem_we_q <= w_beat;
            if (w_beat) begin
                mem_addr_q  <= addr_q;
                mem_wdata_q <= s_wdata;
                mem_wstrb_q <= s_wstrb;
            end
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (!rst && aw_push) begin
            cq_id_q[cq_wr_q]    <= s_awid;
            cq_addr_q[cq_wr_q]  <= s_awaddr;
            cq_len_q[cq_wr_q]   <= s_awlen;
            cq_size_q[cq_wr_q]  <= s_awsize;
            cq_burst_q[cq_wr_q] <= s_awburst;
        end
        if (!rst && w_done) begin
            bq_id_q[bq_wr_q]   <= cq_id_q[cq_rd_q];
            bq_resp_q[bq_wr_q] <= b_resp_new;
        end
    end
endmodule

// File: tb/tb_axi_wr_burst_engine.sv
// Randomized and directed bench for axi_wr_burst_engine against a per-beat
// address/response reference model.
module tb_axi_wr_burst_engine;
    localparam int AW = 32, DW = 64, IDW = 4, DEPTH = 4;
    localparam int MAXSZ = $clog2(DW/8);

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        int          last_at;
    } cmd_t;
    typedef struct packed { logic [31:0] a; logic [63:0] d; logic [7:0] s; } beat_t;
    typedef struct packed { logic [3:0] id; logic [1:0] resp; } bresp_t;

    logic axi_aclk, rst;
    logic [3:0] s_awid; logic [31:0] s_awaddr; logic [7:0] s_awlen;
    logic [2:0] s_awsize; logic [1:0] s_awburst; logic s_awvalid, s_awready;
    logic [63:0] s_wdata; logic [7:0] s_wstrb; logic s_wlast, s_wvalid, s_wready;
    logic [3:0] s_bid; logic [1:0] s_bresp; logic s_bvalid; logic s_bready = 1'b0;
    logic mem_we; logic [31:0] mem_addr; logic [63:0] mem_wdata; logic [7:0] mem_wstrb;
    logic [2:0] cmd_count, b_count;

    axi_wr_burst_engine #(.AW(AW), .DW(DW), .IDW(IDW), .DEPTH(DEPTH)) dut (
        .axi_aclk(axi_aclk), .rst(rst),
        .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
        .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid),
        .s_wready(s_wready), .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid),
        .s_bready(s_bready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .cmd_count(cmd_count), .b_count(b_count)
    );

    int n_chk = 0, n_fail = 0;
    int cyc = 0;
    int bready_mode = 1;
    bit b_pulse = 0;
    int aw_cyc, done_cyc, first_done_cyc, beat_cyc;
    cmd_t   cmd_q[$];
    beat_t  exp_mem[$];
    bresp_t exp_b[$];

    initial begin axi_aclk = 0; forever #5 axi_aclk = ~axi_aclk; end
    always @(posedge axi_aclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference: beat k address straight from the burst definition.
    function automatic logic [31:0] model_addr(input cmd_t c, input int k);
        logic [31:0] bytes, wb, off;
        logic [1:0]  b;
        bit wrap_ok;
        bytes   = 32'd1 << c.size;
        wrap_ok = (c.len == 1) || (c.len == 3) || (c.len == 7) || (c.len == 15);
        b = c.burst;
        if (b == 2'b11 || (b == 2'b10 && !wrap_ok)) b = 2'b01;
        if (b == 2'b00) return c.addr;
        if (b == 2'b01) return c.addr + 32'(k) * bytes;
        wb  = (32'(c.len) + 1) * bytes;
        off = c.addr % wb;
        return (c.addr - off) + ((off + 32'(k) * bytes) % wb);
    endfunction

    function automatic logic [1:0] model_resp(input cmd_t c);
        bit err;
        bit wrap_ok;
        wrap_ok = (c.len == 1) || (c.len == 3) || (c.len == 7) || (c.len == 15);
        err = (int'(c.size) > MAXSZ) || (c.burst == 2'b11) ||
              (c.burst == 2'b10 && !wrap_ok) || (c.last_at != int'(c.len));
        return err ? 2'b10 : 2'b00;
    endfunction

    // Single observer: drives s_bready and scoreboards the memory port and B channel.
    initial forever begin
        @(negedge axi_aclk);
        case (bready_mode)
            0:       s_bready = 1'b0;
            1:       s_bready = 1'b1;
            default: s_bready = ($urandom_range(0, 3) != 0);
        endcase
        if (b_pulse) begin s_bready = 1'b1; b_pulse = 0; end
        if (!rst) begin
            if (mem_we || exp_mem.size() != 0) begin
                chk("mem_we", mem_we, exp_mem.size() != 0);
                if (mem_we && exp_mem.size() != 0) begin
                    beat_t e;
                    e = exp_mem.pop_front();
                    chk("mem_addr", mem_addr, e.a);
                    chk("mem_wdata", mem_wdata, e.d);
                    chk("mem_wstrb", mem_wstrb, e.s);
                end
            end
            if (s_bvalid || exp_b.size() != 0) begin
                chk("bvalid", s_bvalid, exp_b.size() != 0);
                if (s_bvalid && s_bready && exp_b.size() != 0) begin
                    bresp_t e;
                    e = exp_b.pop_front();
                    chk("bid", s_bid, e.id);
                    chk("bresp", s_bresp, e.resp);
                end
            end
        end
    end

    task automatic set_bmode(input int m);
        @(posedge axi_aclk);
        bready_mode = m;
        @(negedge axi_aclk);
    endtask

    task automatic send_aw(input cmd_t c);
        int budget = 0;
        s_awid = c.id; s_awaddr = c.addr; s_awlen = c.len; s_awsize = c.size;
        s_awburst = c.burst; s_awvalid = 1'b1;
        while (!s_awready && budget < 2000) begin @(negedge axi_aclk); budget++; end
        if (!s_awready) begin
            chk("aw_timeout", s_awready, 1'b1);
        end else begin
            @(posedge axi_aclk);
            cmd_q.push_back(c);
            @(negedge axi_aclk);
            aw_cyc = cyc;
        end
        s_awvalid = 1'b0;
    endtask

    task automatic w_beat(input cmd_t c, input int k);
        int budget = 0;
        s_wvalid = 1'b1;
        s_wdata  = {$urandom, $urandom};
        s_wstrb  = 8'($urandom);
        s_wlast  = (k == c.last_at);
        while (!s_wready && budget < 2000) begin @(negedge axi_aclk); budget++; end
        if (!s_wready) begin
            chk("w_timeout", s_wready, 1'b1);
        end else begin
            @(posedge axi_aclk);
            exp_mem.push_back('{a: model_addr(c, k), d: s_wdata, s: s_wstrb});
            if (k == int'(c.len)) exp_b.push_back('{id: c.id, resp: model_resp(c)});
            @(negedge axi_aclk);
            beat_cyc = cyc;
            if (k == int'(c.len)) done_cyc = cyc;
        end
        s_wvalid = 1'b0;
        s_wlast  = 1'b0;
    endtask

    task automatic run_w(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            cmd_t c;
            int budget = 0;
            while (cmd_q.size() == 0 && budget < 2000) begin @(negedge axi_aclk); budget++; end
            if (cmd_q.size() == 0) begin
                chk("cmd_timeout", cmd_q.size(), 1);
                return;
            end
            c = cmd_q.pop_front();
            for (int k = 0; k <= int'(c.len); k++) w_beat(c, k);
            if (i == 0) first_done_cyc = done_cyc;
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge axi_aclk);
        end
    endtask

    task automatic wait_drain();
        int budget = 0;
        while ((exp_b.size() != 0 || exp_mem.size() != 0) && budget < 2000) begin
            @(negedge axi_aclk); budget++;
        end
        chk("drain", exp_b.size() + exp_mem.size(), 0);
    endtask

    function automatic cmd_t mk(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                                input logic [2:0] size, input logic [1:0] burst, input int last_at);
        cmd_t c;
        c.id = id; c.addr = addr; c.len = len; c.size = size; c.burst = burst; c.last_at = last_at;
        return c;
    endfunction

    task automatic one_burst(input cmd_t c);
        send_aw(c);
        run_w(1, 1'b0);
        wait_drain();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_awready"}, s_awready, 1'b1);
        chk({tag, "_wready"}, s_wready, 1'b0);
        chk({tag, "_bvalid"}, s_bvalid, 1'b0);
        chk({tag, "_bid"}, s_bid, 4'd0);
        chk({tag, "_bresp"}, s_bresp, 2'd0);
        chk({tag, "_mem_we"}, mem_we, 1'b0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 64'd0);
        chk({tag, "_mem_wstrb"}, mem_wstrb, 8'd0);
        chk({tag, "_cmd_count"}, cmd_count, 3'd0);
        chk({tag, "_b_count"}, b_count, 3'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_t c;
        cmd_t rc[$];
        rst = 1'b1;
        s_awvalid = 0; s_awid = 0; s_awaddr = 0; s_awlen = 0; s_awsize = 0; s_awburst = 0;
        s_wvalid = 0; s_wdata = 0; s_wstrb = 0; s_wlast = 0;
        repeat (3) @(negedge axi_aclk);
        rst = 1'b0;
        check_reset_vals("reset");

        // INCR id 3: AW-to-wready latency, back-to-back beats, B one cycle after last beat
        c = mk(4'd3, 32'h100, 8'd3, 3'd3, 2'b01, 3);
        send_aw(c);
        chk("aw_wready_n1", s_wready, 1'b0);
        @(negedge axi_aclk);
        chk("aw_wready_n2", s_wready, 1'b1);
        c = cmd_q.pop_front();
        for (int k = 0; k < 4; k++) begin
            w_beat(c, k);
            if (k == 0) first_done_cyc = beat_cyc;
        end
        chk("incr_beat_span", beat_cyc - first_done_cyc, 3);
        chk("b_latency", s_bvalid, 1'b1);
        wait_drain();

        one_burst(mk(4'd1, 32'h118, 8'd3, 3'd3, 2'b10, 3));   // WRAP
        one_burst(mk(4'd2, 32'h40,  8'd2, 3'd3, 2'b00, 2));   // FIXED
        one_burst(mk(4'd4, 32'h200, 8'd3, 3'd3, 2'b01, 1));   // early WLAST
        one_burst(mk(4'd5, 32'h300, 8'd2, 3'd3, 2'b10, 2));   // WRAP bad len
        one_burst(mk(4'd6, 32'h400, 8'd1, 3'd5, 2'b01, 1));   // oversize
        one_burst(mk(4'd7, 32'h500, 8'd1, 3'd2, 2'b11, 1));   // reserved burst

        // Command queue full with W idle
        for (int i = 0; i < 4; i++) send_aw(mk(4'(i + 1), 32'h1000 + 32'(i) * 32'h40, 8'd1, 3'd2, 2'b01, 1));
        chk("cq_full_awready", s_awready, 1'b0);
        chk("cq_full_count", cmd_count, 3'd4);
        fork
            send_aw(mk(4'd9, 32'h2000, 8'd1, 3'd2, 2'b01, 1));
            run_w(5, 1'b0);
        join
        chk("aw5_gap", aw_cyc - first_done_cyc, 1);
        wait_drain();

        // B queue full with s_bready low
        set_bmode(0);
        for (int i = 0; i < 4; i++) send_aw(mk(4'(i + 10), 32'h3000 + 32'(i) * 8, 8'd0, 3'd3, 2'b01, 0));
        run_w(4, 1'b0);
        @(negedge axi_aclk);
        chk("bq_full_count", b_count, 3'd4);
        chk("bq_full_awready", s_awready, 1'b1);
        send_aw(mk(4'd14, 32'h3100, 8'd0, 3'd3, 2'b01, 0));
        @(negedge axi_aclk);
        chk("bq_full_wready", s_wready, 1'b0);
        @(posedge axi_aclk);
        b_pulse = 1;
        @(negedge axi_aclk);
        @(negedge axi_aclk);
        chk("bq_drain_wready", s_wready, 1'b1);
        chk("bq_drain_count", b_count, 3'd3);
        set_bmode(1);
        run_w(1, 1'b0);
        wait_drain();

        // Reset during beat 2 of a len-3 burst
        send_aw(mk(4'd8, 32'h600, 8'd3, 3'd3, 2'b01, 3));
        c = cmd_q.pop_front();
        w_beat(c, 0);
        s_wvalid = 1'b1; s_wdata = 64'hdead; s_wstrb = 8'hff; rst = 1'b1;
        @(negedge axi_aclk);
        check_reset_vals("midrst");
        rst = 1'b0; s_wvalid = 1'b0;
        cmd_q.delete(); exp_b.delete();
        repeat (3) @(negedge axi_aclk);
        one_burst(mk(4'd11, 32'h700, 8'd1, 3'd3, 2'b01, 1));

        // Randomized traffic with random B back-pressure
        set_bmode(2);
        for (int i = 0; i < 40; i++) begin
            int r;
            cmd_t x;
            r = $urandom_range(0, 9);
            x.id    = 4'($urandom);
            x.addr  = $urandom;
            x.len   = (r < 8) ? 8'(r) : ((r == 8) ? 8'd15 : 8'($urandom_range(0, 15)));
            x.size  = ($urandom_range(0, 9) != 0) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
            x.burst = 2'($urandom_range(0, 3));
            x.last_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 16)) : int'(x.len);
            rc.push_back(x);
        end
        fork
            begin
                foreach (rc[i]) begin
                    send_aw(rc[i]);
                    repeat ($urandom_range(0, 3)) @(negedge axi_aclk);
                end
            end
            run_w(40, 1'b1);
        join
        set_bmode(1);
        wait_drain();
        chk("final_cmd_count", cmd_count, 3'd0);
        chk("final_b_count", b_count, 3'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
